// File: rtl/inst_mem_loader_pkg.sv
// ============================================================================
// inst_mem_loader_pkg : shared state encoding and constants for the loader
// Revision 1.0
// ============================================================================
`default_nettype none

package inst_mem_loader_pkg;

  localparam int LD_STATE_W = 3;
  localparam int HDR_BYTES  = 2;   // LEN_HI + LEN_LO

  typedef enum logic [LD_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } ld_state_e;

  function automatic logic is_loading(input ld_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_mem_loader_ld_word_pack.sv
// ============================================================================
// ld_word_pack : packs accepted payload bytes MSB-first into 32-bit words
// Revision 1.0
// ============================================================================
`default_nettype none

module ld_word_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] sr_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (clear_i) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (accept_i) begin
      sr_q  <= {sr_q[15:0], byte_i};
      idx_q <= idx_q + 2'd1;
    end
  end

  // The completed word includes the byte being accepted this cycle.
  assign word_o      = {sr_q, byte_i};
  assign word_done_o = accept_i && (idx_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// ============================================================================
// inst_mem_loader : boot-time byte-stream loader for the instruction RAM
// Revision 1.0
// ============================================================================
`default_nettype none

module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int          WORD_AW     = 17,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_rst_o,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [32:0]    CAP     = 33'd1 << WORD_AW;

  ld_state_e        state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [7:0]       xor_q, xor_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             rx_ready_q, rx_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             pack_clear;
  logic [31:0]      pack_word;
  logic             pack_done;
  logic [15:0]      n_word;

  assign accept = rx_valid && rx_ready_q;
  assign n_word = {len_hi_q, rx_data};

  ld_word_pack u_pack (
    .clk         (clk),
    .rst_n       (rst),
    .clear_i     (pack_clear),
    .accept_i    (accept && (state_q == ST_DATA)),
    .byte_i      (rx_data),
    .word_o      (pack_word),
    .word_done_o (pack_done)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    xor_d      = xor_q;
    to_d       = to_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    pack_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          wcnt_d     = '0;
          xor_d      = '0;
          to_d       = '0;
          pack_clear = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = rx_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = n_word;
          if (n_word == 16'd0)             state_d = ST_CSUM;
          else if ({17'd0, n_word} > CAP)  state_d = ST_ERR;
          else                             state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ rx_data;
          if (pack_done) begin
            mem_we_d   = 1'b1;
            mem_addr_d = BASE_ADDR + {14'd0, wcnt_q, 2'b00};
            mem_data_d = pack_word;
            wcnt_d     = wcnt_q + 16'd1;
            if (wcnt_q == len_q - 16'd1) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) state_d = (rx_data == xor_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte watchdog; only ever fires on a cycle with no accepted byte.
    if (is_loading(state_q)) begin
      if (accept)                to_d = '0;
      else if (to_q == TO_LAST)  state_d = ST_ERR;
      else                       to_d = to_q + 1'b1;
    end

    rx_ready_d = is_loading(state_d);
    busy_d     = is_loading(state_d);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    cpu_rst_d  = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      xor_q      <= '0;
      to_q       <= '0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      xor_q      <= xor_d;
      to_q       <= to_d;
      rx_ready_q <= rx_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign cpu_rst_o = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// ============================================================================
// tb_inst_mem_loader : directed self-checking bench for inst_mem_loader
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_rst_o;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  localparam logic [69:0] RST_VEC = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};

  inst_mem_loader #(
    .WORD_AW     (4),
    .BASE_ADDR   (32'h0000_0000),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_rst_o (cpu_rst_o),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte: rx_ready stuck at %b, required 1 (byte %h)", rx_ready, b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_n2_image(input logic [7:0] csum);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h01); send_byte(8'h11); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h02); send_byte(8'h00); send_byte(8'h20);
    send_byte(csum);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rx_ready, mem_we, mem_addr, mem_data, cpu_rst_o, busy, done, err} !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h",
               {rx_ready, mem_we, mem_addr, mem_data, cpu_rst_o, busy, done, err}, RST_VEC);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_image();
    we_cnt = 0; wa.delete(); wd.delete();
    pulse_start();
    n_checks++;
    if ({rx_ready, busy, cpu_rst_o, done} !== 4'b1110) begin
      n_fail++; $display("FAIL start_levels: got %b required 1110", {rx_ready, busy, cpu_rst_o, done});
    end
    // 34^01^11^00^34^02^00^20 = 32
    send_n2_image(8'h32);
    @(negedge clk);
    n_checks++;
    if (we_cnt !== 2) begin n_fail++; $display("FAIL good_we_count: got %0d required 2", we_cnt); end
    n_checks++;
    if (wa.size() != 2 || wa[0] !== 32'h0 || wd[0] !== 32'h3401_1100) begin
      n_fail++; $display("FAIL good_word0: got size %0d addr %h data %h required 0 / 34011100",
                         wa.size(), wa.size() > 0 ? wa[0] : 32'hx, wd.size() > 0 ? wd[0] : 32'hx);
    end
    n_checks++;
    if (wa.size() != 2 || wa[1] !== 32'h4 || wd[1] !== 32'h3402_0020) begin
      n_fail++; $display("FAIL good_word1: got size %0d required addr 4 data 34020020", wa.size());
    end
    n_checks++;
    if ({done, err, cpu_rst_o, busy, rx_ready} !== 5'b10000) begin
      n_fail++; $display("FAIL good_done: got %b required 10000", {done, err, cpu_rst_o, busy, rx_ready});
    end
    n_checks++;
    if (mem_addr !== 32'h4 || mem_data !== 32'h3402_0020) begin
      n_fail++; $display("FAIL good_hold: got %h/%h required 00000004/34020020", mem_addr, mem_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_csum();
    we_cnt = 0; wa.delete(); wd.delete();
    pulse_start();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL restart_clears_done: got %b required 0", done); end
    send_n2_image(8'h33);
    @(negedge clk);
    n_checks++;
    if (we_cnt !== 2) begin n_fail++; $display("FAIL bad_we_count: got %0d required 2", we_cnt); end
    n_checks++;
    if ({done, err, cpu_rst_o, busy} !== 4'b0110) begin
      n_fail++; $display("FAIL bad_csum_err: got %b required 0110", {done, err, cpu_rst_o, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    we_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    n_checks++;
    if ({done, err, cpu_rst_o} !== 3'b100 || we_cnt !== 0) begin
      n_fail++; $display("FAIL zero_len_ok: got dec %b we %0d required 100 we 0", {done, err, cpu_rst_o}, we_cnt);
    end
    @(posedge clk); #1;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A);
    @(negedge clk);
    n_checks++;
    if ({done, err, cpu_rst_o} !== 3'b011 || we_cnt !== 0) begin
      n_fail++; $display("FAIL zero_len_bad: got dec %b we %0d required 011 we 0", {done, err, cpu_rst_o}, we_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    we_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h11);
    @(negedge clk);
    n_checks++;
    if ({err, rx_ready, busy, cpu_rst_o} !== 4'b1001 || we_cnt !== 0) begin
      n_fail++; $display("FAIL overflow_err: got %b we %0d required 1001 we 0",
                         {err, rx_ready, busy, cpu_rst_o}, we_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    we_cnt = 0; wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h34); send_byte(8'h01);
    repeat (15) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: got err %b busy %b required 0 1", err, busy);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({err, busy, cpu_rst_o, we_cnt == 0} !== 4'b1011) begin
      n_fail++; $display("FAIL timeout_err: got err %b busy %b rst %b we %0d required 1 0 1 0",
                         err, busy, cpu_rst_o, we_cnt);
    end
    @(posedge clk); #1;
    // Recovery load, with a stray start pulse during DATA that must be ignored.
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE);
    start = 1'b1;
    send_byte(8'hAD);
    start = 1'b0;
    send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h22);
    @(negedge clk);
    n_checks++;
    if ({done, err, cpu_rst_o} !== 3'b100) begin
      n_fail++; $display("FAIL recover_done: got %b required 100", {done, err, cpu_rst_o});
    end
    n_checks++;
    if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL recover_word: got size %0d data %h required 1 deadbeef",
                         wa.size(), wd.size() > 0 ? wd[0] : 32'hx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    we_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h01); send_byte(8'h11); send_byte(8'h00); send_byte(8'h34);
    n_checks++;
    if (we_cnt !== 1) begin n_fail++; $display("FAIL pre_reset_we: got %0d required 1", we_cnt); end
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({rx_ready, mem_we, mem_addr, mem_data, cpu_rst_o, busy, done, err} !== RST_VEC) begin
      n_fail++; $display("FAIL async_reset: got %h required %h",
                         {rx_ready, mem_we, mem_addr, mem_data, cpu_rst_o, busy, done, err}, RST_VEC);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    n_checks++;
    if (we_cnt !== 1 || rx_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got we %0d ready %b busy %b required 1 0 0",
                         we_cnt, rx_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_csum();
    test_zero_len();
    test_overflow();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
